// File: rtl/fei4_tx_8b10b.sv
// FE-I4 style 8b10b serial frame transmitter: K28.7, three bytes per FIFO word, K28.3,
// with K28.5 commas while idle. Bit a of each symbol goes out first.

module encode_8b10b (
  input  logic [8:0] datain,
  input  logic       dispin,
  output logic [9:0] dataout,
  output logic       dispout
);
  logic       k;
  logic [4:0] x;
  logic [2:0] y;
  logic [5:0] c6;
  logic [3:0] c4;
  logic [3:0] k4;
  logic [9:0] code;
  logic       rd6;

  always_comb begin
    k  = datain[8];
    x  = datain[4:0];
    y  = datain[7:5];
    // 5b/6b codes in the RD- column (abcdei)
    case (x)
      5'd0:    c6 = 6'b100111;
      5'd1:    c6 = 6'b011101;
      5'd2:    c6 = 6'b101101;
      5'd3:    c6 = 6'b110001;
      5'd4:    c6 = 6'b110101;
      5'd5:    c6 = 6'b101001;
      5'd6:    c6 = 6'b011001;
      5'd7:    c6 = 6'b111000;
      5'd8:    c6 = 6'b111001;
      5'd9:    c6 = 6'b100101;
      5'd10:   c6 = 6'b010101;
      5'd11:   c6 = 6'b110100;
      5'd12:   c6 = 6'b001101;
      5'd13:   c6 = 6'b101100;
      5'd14:   c6 = 6'b011100;
      5'd15:   c6 = 6'b010111;
      5'd16:   c6 = 6'b011011;
      5'd17:   c6 = 6'b100011;
      5'd18:   c6 = 6'b010011;
      5'd19:   c6 = 6'b110010;
      5'd20:   c6 = 6'b001011;
      5'd21:   c6 = 6'b101010;
      5'd22:   c6 = 6'b011010;
      5'd23:   c6 = 6'b111010;
      5'd24:   c6 = 6'b110011;
      5'd25:   c6 = 6'b100110;
      5'd26:   c6 = 6'b010110;
      5'd27:   c6 = 6'b110110;
      5'd28:   c6 = 6'b001110;
      5'd29:   c6 = 6'b101110;
      5'd30:   c6 = 6'b011110;
      default: c6 = 6'b101011;
    endcase
    rd6 = dispin ^ ($countones(c6) != 3);
    case (y)
      3'd0:    c4 = 4'b1011;
      3'd1:    c4 = 4'b1001;
      3'd2:    c4 = 4'b0101;
      3'd3:    c4 = 4'b1100;
      3'd4:    c4 = 4'b1101;
      3'd5:    c4 = 4'b1010;
      3'd6:    c4 = 4'b0110;
      // alternate x.7 avoids a run of five equal bits across the sub-block boundary
      default: c4 = ((!rd6 && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                     (rd6 && (x == 5'd11 || x == 5'd13 || x == 5'd14))) ? 4'b0111 : 4'b1110;
    endcase
    case (y)
      3'd0:    k4 = 4'b0100;
      3'd1:    k4 = 4'b1001;
      3'd2:    k4 = 4'b0101;
      3'd3:    k4 = 4'b0011;
      3'd4:    k4 = 4'b0010;
      3'd5:    k4 = 4'b1010;
      3'd6:    k4 = 4'b0110;
      default: k4 = 4'b1000;
    endcase
    code[9:4] = (dispin && ($countones(c6) != 3 || x == 5'd7)) ? ~c6 : c6;
    code[3:0] = (rd6 && ($countones(c4) != 2 || y == 3'd3)) ? ~c4 : c4;
    if (k)
      code = dispin ? ~{6'b001111, k4} : {6'b001111, k4};
    dataout = code;
    dispout = dispin ^ ($countones(code) != 5);
  end
endmodule

module fei4_tx_8b10b #(
  parameter int unsigned MAX_WORDS = 16
) (
  input  logic        FCLK,
  input  logic        RESET,
  input  logic        ENABLE,
  input  logic        invert_tx_data,
  input  logic [23:0] data,
  input  logic        empty,
  output logic        read,
  output logic        TX_DATA,
  output logic        busy,
  output logic [15:0] word_cnt,
  output logic [15:0] frame_cnt
);
  localparam logic [15:0] MAX_W = 16'(MAX_WORDS);

  typedef enum logic [2:0] {IDLE, SOF, D0, D1, D2, EOF} state_t;

  state_t      state, state_nxt;
  logic [3:0]  bit_cnt;
  logic        load;
  logic        take;
  logic [8:0]  shreg;
  logic        rd;
  logic [15:0] hold_lo;
  logic [15:0] frame_words;
  logic [8:0]  enc_in;
  logic [9:0]  enc_out;
  logic        enc_disp;

  assign load = (bit_cnt == 4'd9);
  // SOF always starts a fresh frame, so its word limit check is trivially met
  assign take = !empty && (state == SOF || frame_words < MAX_W);

  always_ff @(posedge FCLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (load) begin
      case (state)
        IDLE:    if (ENABLE && !empty) state_nxt = SOF;
        SOF, D2: state_nxt = take ? D0 : EOF;
        D0:      state_nxt = D1;
        D1:      state_nxt = D2;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // D0 encodes straight from the FIFO head because the hold register latches on the same edge
  always_comb begin
    read   = load && take && (state == SOF || state == D2);
    enc_in = {1'b1, 8'hBC};
    case (state_nxt)
      SOF:     enc_in = {1'b1, 8'hFC};
      D0:      enc_in = {1'b0, data[23:16]};
      D1:      enc_in = {1'b0, hold_lo[15:8]};
      D2:      enc_in = {1'b0, hold_lo[7:0]};
      EOF:     enc_in = {1'b1, 8'h7C};
      default: enc_in = {1'b1, 8'hBC};
    endcase
  end

  encode_8b10b u_enc (
    .datain  (enc_in),
    .dispin  (rd),
    .dataout (enc_out),
    .dispout (enc_disp)
  );

  always_ff @(posedge FCLK or posedge RESET) begin
    if (RESET) begin
      bit_cnt     <= 4'd9;
      shreg       <= '0;
      TX_DATA     <= 1'b0;
      rd          <= 1'b0;
      busy        <= 1'b0;
      hold_lo     <= '0;
      frame_words <= '0;
      word_cnt    <= '0;
      frame_cnt   <= '0;
    end else begin
      if (load) begin
        bit_cnt <= 4'd0;
        shreg   <= enc_out[8:0];
        TX_DATA <= enc_out[9] ^ invert_tx_data;
        rd      <= enc_disp;
        busy    <= (state_nxt != IDLE);
        if (read) begin
          hold_lo     <= data[15:0];
          frame_words <= (state == SOF) ? 16'd1 : frame_words + 16'd1;
        end
        if (state == EOF && frame_cnt != 16'hFFFF)
          frame_cnt <= frame_cnt + 16'd1;
      end else begin
        bit_cnt <= bit_cnt + 4'd1;
        shreg   <= {shreg[7:0], 1'b0};
        TX_DATA <= shreg[8] ^ invert_tx_data;
      end
      if (read) word_cnt <= word_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_fei4_tx_8b10b.sv
// Directed bench for fei4_tx_8b10b: FWFT FIFO model, expected-byte scoreboard and a
// brute-force 8b10b line decoder that tracks running disparity and frame structure.
`timescale 1ns/1ps
module tb_fei4_tx_8b10b;
  logic        FCLK = 1'b0;
  logic        RESET = 1'b1;
  logic        ENABLE = 1'b0;
  logic        invert_tx_data = 1'b0;
  logic [23:0] data = '0;
  logic        empty = 1'b1;
  logic        read, TX_DATA, busy;
  logic [15:0] word_cnt, frame_cnt;

  int total = 0;
  int bad = 0;

  logic [23:0] fifo[$];
  logic [7:0]  exp_q[$];
  int          fw_q[$];

  bit       mon_on = 1'b0;
  int       mon_bits;
  logic [9:0] mon_sh;
  bit       mon_rd;
  bit       in_frame;
  int       idle_syms;
  int       frame_bytes;
  int       frames_seen = 0;
  bit       first_sym;

  int cyc = 0;
  int read_pulses = 0;
  int read_cyc = -1;
  int busy_start = -1;
  int busy_len = 0;
  bit busy_prev = 1'b0;

  always #5 FCLK = ~FCLK;

  fei4_tx_8b10b #(.MAX_WORDS(16)) dut (
    .FCLK           (FCLK),
    .RESET          (RESET),
    .ENABLE         (ENABLE),
    .invert_tx_data (invert_tx_data),
    .data           (data),
    .empty          (empty),
    .read           (read),
    .TX_DATA        (TX_DATA),
    .busy           (busy),
    .word_cnt       (word_cnt),
    .frame_cnt      (frame_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [5:0] tab6(input logic [4:0] x);
    case (x)
      5'd0:  return 6'b100111;  5'd1:  return 6'b011101;  5'd2:  return 6'b101101;
      5'd3:  return 6'b110001;  5'd4:  return 6'b110101;  5'd5:  return 6'b101001;
      5'd6:  return 6'b011001;  5'd7:  return 6'b111000;  5'd8:  return 6'b111001;
      5'd9:  return 6'b100101;  5'd10: return 6'b010101;  5'd11: return 6'b110100;
      5'd12: return 6'b001101;  5'd13: return 6'b101100;  5'd14: return 6'b011100;
      5'd15: return 6'b010111;  5'd16: return 6'b011011;  5'd17: return 6'b100011;
      5'd18: return 6'b010011;  5'd19: return 6'b110010;  5'd20: return 6'b001011;
      5'd21: return 6'b101010;  5'd22: return 6'b011010;  5'd23: return 6'b111010;
      5'd24: return 6'b110011;  5'd25: return 6'b100110;  5'd26: return 6'b010110;
      5'd27: return 6'b110110;  5'd28: return 6'b001110;  5'd29: return 6'b101110;
      5'd30: return 6'b011110;  default: return 6'b101011;
    endcase
  endfunction

  function automatic logic [3:0] tab4(input logic [2:0] y, input bit alt);
    case (y)
      3'd0: return 4'b1011;  3'd1: return 4'b1001;  3'd2: return 4'b0101;
      3'd3: return 4'b1100;  3'd4: return 4'b1101;  3'd5: return 4'b1010;
      3'd6: return 4'b0110;  default: return alt ? 4'b0111 : 4'b1110;
    endcase
  endfunction

  function automatic bit rd_after(input int ones, input bit rd_in, input int bal);
    if (ones > bal) return 1'b1;
    if (ones < bal) return 1'b0;
    return rd_in;
  endfunction

  function automatic logic [9:0] enc10(input bit k, input logic [7:0] b, input bit rd);
    logic [9:0] c;
    logic [5:0] s6;
    logic [3:0] s4;
    logic [4:0] x;
    bit r6, alt;
    if (k) begin
      case (b)
        8'hBC:   c = 10'b0011111010;
        8'hFC:   c = 10'b0011111000;
        default: c = 10'b0011110011;
      endcase
      return rd ? ~c : c;
    end
    x  = b[4:0];
    s6 = tab6(x);
    if (rd && ($countones(s6) != 3 || x == 5'd7)) s6 = ~s6;
    r6  = rd_after($countones(s6), rd, 3);
    alt = (!r6 && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
          (r6 && (x == 5'd11 || x == 5'd13 || x == 5'd14));
    s4 = tab4(b[7:5], alt);
    if (r6 && ($countones(s4) != 2 || b[7:5] == 3'd3)) s4 = ~s4;
    return {s6, s4};
  endfunction

  task automatic decode(input logic [9:0] s, input bit rd, output bit ok, output bit k, output logic [7:0] b);
    logic [7:0] kl[3];
    kl[0] = 8'hBC; kl[1] = 8'hFC; kl[2] = 8'h7C;
    ok = 1'b0; k = 1'b0; b = 8'h00;
    for (int i = 0; i < 3; i++)
      if (!ok && enc10(1'b1, kl[i], rd) == s) begin ok = 1'b1; k = 1'b1; b = kl[i]; end
    for (int d = 0; d < 256; d++)
      if (!ok && enc10(1'b0, 8'(d), rd) == s) begin ok = 1'b1; b = 8'(d); end
  endtask

  task automatic mon_reset();
    mon_bits = 0; mon_sh = '0; mon_rd = 1'b0; in_frame = 1'b0;
    idle_syms = 0; frame_bytes = 0; frames_seen = 0; first_sym = 1'b1;
    fw_q.delete();
  endtask

  task automatic process_sym(input logic [9:0] s);
    bit ok, k;
    logic [7:0] b;
    if (first_sym) begin
      check("first_comma_rd_neg", 32'(s), 32'(10'b0011111010));
      first_sym = 1'b0;
    end
    decode(s, mon_rd, ok, k, b);
    check("line_code_valid", 32'(ok), 32'd1);
    if (!ok) return;
    mon_rd = rd_after($countones(s), mon_rd, 5);
    if (k && b == 8'hBC) begin
      check("comma_outside_frame", 32'(in_frame), 32'd0);
      idle_syms++;
    end else if (k && b == 8'hFC) begin
      check("sof_after_comma", 32'(!in_frame && idle_syms > 0), 32'd1);
      in_frame = 1'b1; frame_bytes = 0;
    end else if (k) begin
      check("eof_in_frame", 32'(in_frame), 32'd1);
      check("eof_word_aligned", 32'(frame_bytes % 3), 32'd0);
      check("frame_max_words", 32'(frame_bytes / 3 <= 16), 32'd1);
      fw_q.push_back(frame_bytes / 3);
      frames_seen++; in_frame = 1'b0; idle_syms = 0;
    end else begin
      check("data_in_frame", 32'(in_frame), 32'd1);
      check("data_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("data_byte", 32'(b), 32'(exp_q.pop_front()));
      frame_bytes++;
    end
  endtask

  task automatic refresh_fifo();
    empty = (fifo.size() == 0);
    data  = empty ? 24'h0 : fifo[0];
  endtask

  task automatic push_word(input logic [23:0] w);
    fifo.push_back(w);
    exp_q.push_back(w[23:16]); exp_q.push_back(w[15:8]); exp_q.push_back(w[7:0]);
    refresh_fifo();
  endtask

  // One FCLK cycle: sample strobes mid-cycle, then the line bit and FIFO pop after the edge
  task automatic tick();
    bit rd_seen;
    @(negedge FCLK);
    rd_seen = read;
    if (rd_seen) begin read_pulses++; read_cyc = cyc; end
    if (busy && !busy_prev) busy_start = cyc;
    if (busy) busy_len++;
    busy_prev = busy;
    @(posedge FCLK);
    #1;
    cyc++;
    if (rd_seen && fifo.size() > 0) void'(fifo.pop_front());
    refresh_fifo();
    if (mon_on) begin
      mon_sh = {mon_sh[8:0], TX_DATA ^ invert_tx_data};
      mon_bits++;
      if (mon_bits == 10) begin
        mon_bits = 0;
        process_sym(mon_sh);
      end
    end
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames_seen < target && n < budget) begin tick(); n++; end
    check("frame_timeout", 32'(frames_seen >= target), 32'd1);
  endtask

  task automatic wait_read(input int budget);
    int n = 0;
    int start = read_pulses;
    while (read_pulses == start && n < budget) begin tick(); n++; end
    check("read_timeout", 32'(read_pulses > start), 32'd1);
  endtask

  initial begin
    refresh_fifo();
    mon_reset();
    repeat (3) tick();
    check("rst_tx_data", 32'(TX_DATA), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_read", 32'(read), 32'd0);
    check("rst_word_cnt", 32'(word_cnt), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);

    RESET = 1'b0; mon_on = 1'b1;
    repeat (100) tick();
    check("idle_commas", 32'(idle_syms), 32'd10);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_no_read", 32'(read_pulses), 32'd0);

    invert_tx_data = 1'b1;
    repeat (40) tick();
    invert_tx_data = 1'b0;
    repeat (20) tick();
    check("invert_commas", 32'(idle_syms), 32'd16);
    check("invert_no_frame", 32'(frames_seen), 32'd0);

    busy_len = 0; busy_start = -1; read_cyc = -1;
    ENABLE = 1'b1;
    push_word(24'h123456);
    wait_frames(1, 400);
    repeat (20) tick();
    check("one_word_frame_len", 32'(fw_q.size() > 0 ? fw_q.pop_front() : -1), 32'd1);
    check("one_word_word_cnt", 32'(word_cnt), 32'd1);
    check("one_word_frame_cnt", 32'(frame_cnt), 32'd1);
    check("one_word_reads", 32'(read_pulses), 32'd1);
    check("one_word_busy_cycles", 32'(busy_len), 32'd50);
    check("sof_to_read_cycles", 32'(read_cyc - busy_start), 32'd9);
    check("one_word_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    for (int i = 0; i < 40; i++) push_word({8'(i), 8'(i * 7 + 3), 8'(8'hF0 ^ 8'(i))});
    wait_frames(4, 3000);
    repeat (20) tick();
    check("burst_frame1_words", 32'(fw_q.size() > 0 ? fw_q.pop_front() : -1), 32'd16);
    check("burst_frame2_words", 32'(fw_q.size() > 0 ? fw_q.pop_front() : -1), 32'd16);
    check("burst_frame3_words", 32'(fw_q.size() > 0 ? fw_q.pop_front() : -1), 32'd8);
    check("burst_word_cnt", 32'(word_cnt), 32'd41);
    check("burst_frame_cnt", 32'(frame_cnt), 32'd4);
    check("burst_reads", 32'(read_pulses), 32'd41);

    push_word(24'hC0FFEE);
    wait_read(200);
    repeat (35) tick();
    push_word(24'h00FF81);
    wait_frames(6, 600);
    repeat (20) tick();
    check("empty_rise_frame_a", 32'(fw_q.size() > 0 ? fw_q.pop_front() : -1), 32'd1);
    check("empty_rise_frame_b", 32'(fw_q.size() > 0 ? fw_q.pop_front() : -1), 32'd1);
    check("empty_rise_word_cnt", 32'(word_cnt), 32'd43);
    check("empty_rise_frame_cnt", 32'(frame_cnt), 32'd6);

    push_word(24'hA5A55A);
    push_word(24'h3C3CC3);
    wait_read(200);
    repeat (15) tick();
    mon_on = 1'b0;
    RESET = 1'b1;
    #1;
    check("midrst_tx_data", 32'(TX_DATA), 32'd0);
    check("midrst_word_cnt", 32'(word_cnt), 32'd0);
    check("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    ENABLE = 1'b0;
    fifo.delete(); exp_q.delete();
    refresh_fifo();
    repeat (3) tick();
    RESET = 1'b0;
    mon_reset(); mon_on = 1'b1; read_pulses = 0;
    repeat (50) tick();
    check("postrst_commas", 32'(idle_syms), 32'd5);
    check("postrst_no_frame", 32'(frames_seen), 32'd0);
    check("postrst_no_read", 32'(read_pulses), 32'd0);

    ENABLE = 1'b1;
    push_word(24'h0F1E2D);
    wait_frames(1, 400);
    repeat (20) tick();
    check("postrst_frame_words", 32'(fw_q.size() > 0 ? fw_q.pop_front() : -1), 32'd1);
    check("postrst_word_cnt", 32'(word_cnt), 32'd1);
    check("postrst_frame_cnt", 32'(frame_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
